mux_4x1_rr_ctrl: RTL

//   Round-robin controller directly upstream of mux_4x1_param: drives its sel input.

---
 rtl/mux_4x1_rr_ctrl_if.sv | 24 ++
 rtl/mux_4x1_rr_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/mux_4x1_rr_ctrl_if.sv
// Bus between the round-robin collector, its four requesters, the mux_4x1_param
// it steers, and the downstream consumer. fsm_state mirrors the controller FSM.
interface mux_4x1_rr_ctrl_if #(
  parameter int N = 4
);
  logic [3:0]   req;
  logic [N-1:0] mux_out;
  logic [1:0]   sel;
  logic [3:0]   gnt;
  logic [N-1:0] dout;
  logic         dout_valid;
  logic         dout_ready;
  logic [1:0]   fsm_state;

  modport master (
    input  req, mux_out, dout_ready,
    output sel, gnt, dout, dout_valid, fsm_state
  );

  modport slave (
    output req, mux_out, dout_ready,
    input  sel, gnt, dout, dout_valid, fsm_state
  );
endinterface

// File: rtl/mux_4x1_rr_ctrl.sv
// Round-robin controller for mux_4x1_param: steers sel, registers the chosen word
// into a valid/ready stage, and pulses gnt[i]. Define MUX_RR_CNT_EN for grant_cnt.
module mux_4x1_rr_ctrl #(
  parameter int N = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mux_4x1_rr_ctrl_if.master      bus
`ifdef MUX_RR_CNT_EN
  ,
  output logic [15:0]            grant_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   sel_q, sel_d;
  logic [1:0]   last_q, last_d;
  logic [N-1:0] dout_q, dout_d;
  logic         dout_valid_q, dout_valid_d;
  logic [3:0]   gnt_q, gnt_d;
  logic         found;
  logic [1:0]   pick;
`ifdef MUX_RR_CNT_EN
  logic [15:0]  grant_cnt_q, grant_cnt_d;
`endif

  // Search starts just past the last granted channel, so that channel ranks last.
  always_comb begin
    found = 1'b0;
    pick  = sel_q;
    for (int k = 1; k <= 4; k++) begin
      if (!found && bus.req[2'(last_q + 2'(k))]) begin
        found = 1'b1;
        pick  = 2'(last_q + 2'(k));
      end
    end
  end

  // Handshake: a word transfers on a rising edge where dout_valid and dout_ready
  // are both high; dout is held stable while dout_valid is high and not accepted.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_d       = last_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    gnt_d        = 4'b0000;
`ifdef MUX_RR_CNT_EN
    grant_cnt_d  = grant_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = pick;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (bus.req[sel_q]) begin
          dout_d       = bus.mux_out;
          dout_valid_d = 1'b1;
          state_d      = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (bus.dout_ready) begin
          dout_valid_d = 1'b0;
          gnt_d        = 4'b0001 << sel_q;
          last_d       = sel_q;
`ifdef MUX_RR_CNT_EN
          grant_cnt_d  = grant_cnt_q + 16'd1;
`endif
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= 2'd0;
      last_q       <= 2'd3;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      gnt_q        <= 4'b0000;
`ifdef MUX_RR_CNT_EN
      grant_cnt_q  <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_q       <= last_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      gnt_q        <= gnt_d;
`ifdef MUX_RR_CNT_EN
      grant_cnt_q  <= grant_cnt_d;
`endif
    end
  end

  assign bus.sel        = sel_q;
  assign bus.gnt        = gnt_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.fsm_state  = state_q;
`ifdef MUX_RR_CNT_EN
  assign grant_cnt      = grant_cnt_q;
`endif

endmodule
